// File: rtl/protobuf_pkg.sv
// Shared types and helpers for the protobuf field encoder.
// Mode/wire-type encodings, FSM states, zigzag and varint sizing.
package protobuf_pkg;

    typedef enum logic [2:0] {
        M_VARINT  = 3'd0,
        M_SINT    = 3'd1,
        M_FIXED64 = 3'd2,
        M_LEN     = 3'd3,
        M_FIXED32 = 3'd4
    } pb_mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TAG,
        S_VALUE
    } pb_state_e;

    localparam logic [2:0] WT_VARINT = 3'd0;
    localparam logic [2:0] WT_I64    = 3'd1;
    localparam logic [2:0] WT_LEN    = 3'd2;
    localparam logic [2:0] WT_I32    = 3'd5;

    localparam logic [2:0] MODE_MAX  = 3'd4;

    function automatic logic [63:0] zigzag(
        input logic [63:0] value,
        input int unsigned width
    );
        logic [63:0] mask;
        logic [63:0] sign;
        logic [5:0]  msb;
        msb  = 6'(width - 1);
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        sign = value[msb] ? '1 : '0;
        return ((value << 1) ^ sign) & mask;
    endfunction

    function automatic int varint_len(input int width);
        return (width + 6) / 7;
    endfunction

    function automatic logic [2:0] wire_type(input pb_mode_e mode);
        logic [2:0] wt;
        wt = WT_VARINT;
        case (mode)
            M_FIXED64: wt = WT_I64;
            M_LEN:     wt = WT_LEN;
            M_FIXED32: wt = WT_I32;
            default:   wt = WT_VARINT;
        endcase
        return wt;
    endfunction

endpackage

// File: rtl/protobuf_field_encoder_if.sv
// Descriptor-in / byte-out handshake bundle for the field encoder.
// slave is the encoder's view, master is the producer/consumer side.
interface protobuf_field_encoder_if #(
    parameter int DATA_W  = 64,
    parameter int FIELD_W = 29
) ();

    logic               in_valid;
    logic               in_ready;
    logic [FIELD_W-1:0] in_field;
    logic [2:0]         in_mode;
    logic [DATA_W-1:0]  in_data;

    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_data;
    logic               out_last;

    modport master (
        output in_valid, in_field, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_field, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/pb_varint_shifter.sv
// Varint remainder register: load a value, shift 7 bits per byte.
// byte_o carries the continuation bit; last_o flags the final byte.
module pb_varint_shifter #(
    parameter int W = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_i,
    output logic [7:0]   byte_o,
    output logic         last_o
);

    logic [W-1:0] rem_q;
    logic [W-1:0] rem_d;

    // Load has priority over shift so a chained field can reload.
    always_comb begin
        rem_d = rem_q;
        if (load_i) begin
            rem_d = load_val_i;
        end else if (shift_i) begin
            rem_d = rem_q >> 7;
        end
    end

    // Remainder register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    // Current byte: low 7 bits plus "more follows" flag.
    always_comb begin
        last_o = (rem_q[W-1:7] == '0);
        byte_o = {~last_o, rem_q[6:0]};
    end

endmodule

// File: rtl/protobuf_field_encoder.sv
// Streaming protobuf field encoder: tag varint then value bytes.
// One descriptor per handshake, one byte per cycle, chains with no bubble.
module protobuf_field_encoder
    import protobuf_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int FIELD_W = 29,
    parameter int COUNT_W = 32
) (
    input  logic                   clock_clk,
    input  logic                   reset_reset_n,
    protobuf_field_encoder_if.slave bus,
    output logic                   err,
    output logic [COUNT_W-1:0]     byte_count,
    input  logic                   count_clr
);

    localparam int TAG_W = FIELD_W + 3;
    localparam int SH_W  = (DATA_W > TAG_W) ? DATA_W : TAG_W;

    pb_state_e    state_q, state_d;
    pb_mode_e     mode_q, mode_d;
    logic [63:0]  val_q, val_d;
    logic [3:0]   bcnt_q, bcnt_d;
    logic         err_q, err_d;
    logic [COUNT_W-1:0] cnt_q;

    logic         sh_load;
    logic         sh_shift;
    logic [SH_W-1:0] sh_val;
    logic [7:0]   sh_byte;
    logic         sh_last;

    logic         in_legal;
    logic [TAG_W-1:0] in_tag;
    logic [63:0]  in_val;
    logic         is_fixed;
    logic         fix_last;
    logic [3:0]   fix_n;

    logic         in_ready_c;
    logic         out_valid_c;
    logic [7:0]   out_data_c;
    logic         out_last_c;
    logic         out_hs;
    logic         accept;

    pb_varint_shifter #(
        .W (SH_W)
    ) u_shifter (
        .clk_i      (clock_clk),
        .rst_ni     (reset_reset_n),
        .load_i     (sh_load),
        .load_val_i (sh_val),
        .shift_i    (sh_shift),
        .byte_o     (sh_byte),
        .last_o     (sh_last)
    );

    // Decode the incoming descriptor into tag and value register image.
    always_comb begin
        in_legal = (bus.in_field != '0) && (bus.in_mode <= MODE_MAX);
        in_tag   = {bus.in_field, wire_type(pb_mode_e'(bus.in_mode))};
        in_val   = 64'(bus.in_data);
        if (pb_mode_e'(bus.in_mode) == M_SINT) begin
            in_val = zigzag(64'(bus.in_data), DATA_W);
        end
        is_fixed = (mode_q == M_FIXED64) || (mode_q == M_FIXED32);
        fix_n    = (mode_q == M_FIXED64) ? 4'd7 : 4'd3;
        fix_last = (bcnt_q == fix_n);
    end

    // FSM next state, byte mux and shifter control.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        val_d       = val_q;
        bcnt_d      = bcnt_q;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        sh_val      = '0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_data_c  = '0;
        out_last_c  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
            end
            S_TAG: begin
                out_valid_c = 1'b1;
                out_data_c  = sh_byte;
            end
            S_VALUE: begin
                out_valid_c = 1'b1;
                if (is_fixed) begin
                    out_data_c = val_q[{bcnt_q[2:0], 3'b000} +: 8];
                    out_last_c = fix_last;
                end else begin
                    out_data_c = sh_byte;
                    out_last_c = sh_last;
                end
            end
            default: ;
        endcase

        out_hs = out_valid_c && bus.out_ready;
        if ((state_q == S_VALUE) && out_hs && out_last_c) begin
            in_ready_c = 1'b1;
        end
        accept = bus.in_valid && in_ready_c;
        err_d  = accept && !in_legal;

        unique case (state_q)
            S_IDLE: ;
            S_TAG: begin
                if (out_hs) begin
                    if (sh_last) begin
                        state_d = S_VALUE;
                        bcnt_d  = '0;
                        if (!is_fixed) begin
                            sh_load = 1'b1;
                            sh_val  = val_q[SH_W-1:0];
                        end
                    end else begin
                        sh_shift = 1'b1;
                    end
                end
            end
            S_VALUE: begin
                if (out_hs) begin
                    if (out_last_c) begin
                        state_d = S_IDLE;
                    end else if (is_fixed) begin
                        bcnt_d = bcnt_q + 4'd1;
                    end else begin
                        sh_shift = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept && in_legal) begin
            state_d = S_TAG;
            mode_d  = pb_mode_e'(bus.in_mode);
            val_d   = in_val;
            sh_load = 1'b1;
            sh_val  = SH_W'(in_tag);
        end
    end

    // FSM and field registers.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
            mode_q  <= M_VARINT;
            val_q   <= '0;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            val_q   <= val_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
        end
    end

    // Emitted-byte counter; clear beats a same-cycle handshake.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt_q <= '0;
        end else if (count_clr) begin
            cnt_q <= '0;
        end else if (out_hs) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;
    assign bus.out_last  = out_last_c;
    assign err           = err_q;
    assign byte_count    = cnt_q;

endmodule

// File: tb/tb_protobuf_field_encoder.sv
// Directed bench for protobuf_field_encoder.
// Cycle-stepped driver, byte collector and hand-computed streams.
`timescale 1ns/1ps
module tb_protobuf_field_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        count_clr = 1'b0;
    logic        err;
    logic [31:0] byte_count;

    always #5 clk = ~clk;

    protobuf_field_encoder_if #(.DATA_W(64), .FIELD_W(29)) bus ();

    protobuf_field_encoder #(
        .DATA_W  (64),
        .FIELD_W (29),
        .COUNT_W (32)
    ) dut (
        .clock_clk     (clk),
        .reset_reset_n (rst_n),
        .bus           (bus),
        .err           (err),
        .byte_count    (byte_count),
        .count_clr     (count_clr)
    );

    typedef struct {
        logic [28:0] f;
        logic [2:0]  m;
        logic [63:0] d;
    } desc_t;

    desc_t       pend_q[$];
    logic [8:0]  rx_q[$];
    int          total = 0;
    int          bad = 0;
    int          want = 0;
    int          gaps = 0;
    int          cyc = 0;
    int          err_cnt = 0;
    bit          bp_rand = 1'b0;
    bit          hold_v = 1'b0;
    logic [7:0]  hold_d;
    logic        hold_l;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [28:0] f, input logic [2:0] m,
                       input logic [63:0] d);
        desc_t x;
        x.f = f;
        x.m = m;
        x.d = d;
        pend_q.push_back(x);
    endtask

    task automatic step();
        @(negedge clk);
        bus.out_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend_q.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_field = pend_q[0].f;
            bus.in_mode  = pend_q[0].m;
            bus.in_data  = pend_q[0].d;
        end else begin
            bus.in_valid = 1'b0;
        end
        #1;
        if (hold_v) begin
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_data", 64'(bus.out_data), 64'(hold_d));
            chk("stall_last", 64'(bus.out_last), 64'(hold_l));
        end
        if (err) err_cnt++;
        if (rx_q.size() > 0 && rx_q.size() < want && !bus.out_valid) gaps++;
        hold_v = bus.out_valid && !bus.out_ready;
        hold_d = bus.out_data;
        hold_l = bus.out_last;
        if (bus.out_valid && bus.out_ready)
            rx_q.push_back({bus.out_last, bus.out_data});
        if (bus.in_valid && bus.in_ready)
            void'(pend_q.pop_front());
        cyc++;
    endtask

    task automatic run(input int n, output int cycles);
        want = n;
        rx_q.delete();
        gaps = 0;
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            if (pend_q.size() == 0 && rx_q.size() >= n) break;
            step();
        end
        cycles = cyc;
        chk("drain", 64'(rx_q.size()), 64'(n));
    endtask

    task automatic expect_bytes(input string tag, input logic [8:0] exp[$]);
        chk({tag, "_len"}, 64'(rx_q.size()), 64'(exp.size()));
        foreach (exp[i]) begin
            if (i < rx_q.size())
                chk($sformatf("%s_b%0d", tag, i), 64'(rx_q[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [8:0] e[$];

        bus.in_valid  = 1'b0;
        bus.in_field  = '0;
        bus.in_mode   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_last", 64'(bus.out_last), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_count", 64'(byte_count), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // field 1 VARINT 150
        put(29'd1, 3'd0, 64'd150);
        run(3, c);
        e = '{9'h008, 9'h096, 9'h101};
        expect_bytes("v150", e);
        chk("v150_lat", 64'(c), 64'd4);
        step();
        chk("v150_count", 64'(byte_count), 64'd3);

        // field 2 SINT -1 and +1
        put(29'd2, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        run(2, c);
        e = '{9'h010, 9'h101};
        expect_bytes("sint_m1", e);
        put(29'd2, 3'd1, 64'd1);
        run(2, c);
        e = '{9'h010, 9'h102};
        expect_bytes("sint_p1", e);

        // field 16 FIXED32 0x12345678
        put(29'd16, 3'd4, 64'h1234_5678);
        run(6, c);
        e = '{9'h085, 9'h001, 9'h078, 9'h056, 9'h034, 9'h112};
        expect_bytes("fx32", e);

        // max varint chained with FIXED64 zero, no bubble
        put(29'd1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        put(29'd3, 3'd2, 64'd0);
        run(20, c);
        e.delete();
        e.push_back(9'h008);
        for (int i = 0; i < 9; i++) e.push_back(9'h0FF);
        e.push_back(9'h101);
        e.push_back(9'h019);
        for (int i = 0; i < 7; i++) e.push_back(9'h000);
        e.push_back(9'h100);
        expect_bytes("chain", e);
        chk("chain_cycles", 64'(c), 64'd21);
        chk("chain_gaps", 64'(gaps), 64'd0);

        // random backpressure, back-to-back descriptors
        bp_rand = 1'b1;
        put(29'd1, 3'd0, 64'd150);
        put(29'd16, 3'd4, 64'h1234_5678);
        put(29'd2, 3'd1, 64'd1);
        run(11, c);
        bp_rand = 1'b0;
        e = '{9'h008, 9'h096, 9'h101,
              9'h085, 9'h001, 9'h078, 9'h056, 9'h034, 9'h112,
              9'h010, 9'h102};
        expect_bytes("bp", e);
        step();
        chk("bp_count", 64'(byte_count), 64'd44);

        // clear held across a field: only the final byte counts
        count_clr = 1'b1;
        put(29'd1, 3'd0, 64'd150);
        run(3, c);
        count_clr = 1'b0;
        step();
        chk("clr_hs", 64'(byte_count), 64'd1);

        // illegal descriptors dropped, then a legal one
        err_cnt = 0;
        put(29'd0, 3'd0, 64'd5);
        put(29'd1, 3'd6, 64'd7);
        put(29'd1, 3'd0, 64'd150);
        run(3, c);
        e = '{9'h008, 9'h096, 9'h101};
        expect_bytes("illegal", e);
        chk("illegal_err", 64'(err_cnt), 64'd2);
        chk("illegal_cycles", 64'(c), 64'd6);

        // reset in the middle of a FIXED64 field
        want = 0;
        rx_q.delete();
        put(29'd3, 3'd2, 64'h1122_3344_5566_7788);
        repeat (4) step();
        chk("mid_bytes", 64'(rx_q.size()), 64'd3);
        chk("mid_tag", 64'(rx_q[0]), 64'h019);
        chk("mid_b1", 64'(rx_q[1]), 64'h088);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_last", 64'(bus.out_last), 64'd0);
        chk("mid_rst_count", 64'(byte_count), 64'd0);
        pend_q.delete();
        hold_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        put(29'd1, 3'd0, 64'd150);
        run(3, c);
        e = '{9'h008, 9'h096, 9'h101};
        expect_bytes("restart", e);
        step();
        chk("restart_count", 64'(byte_count), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
